// File: rtl/t2mi_ts_encapsulator.sv
// ---------------------------------------------------------------------------
// t2mi_ts_encapsulator
// Wraps the byte stream from the T2-MI packet builder into 188-byte MPEG-TS
// packets on a single PID. Input bytes are buffered in a 2**FIFO_AW byte FIFO.
// The absolute stream position of every T2-MI start byte is queued. When the
// FIFO holds a full payload, one TS packet is emitted with the matching
// pointer_field, PUSI, continuity counter and adaptation-field padding.
//
// Ports
//   CLK          clock (single domain)
//   RST          synchronous active-high reset; flushes FIFO/queue, aborts packet
//   DATA_IN      T2-MI byte
//   VALID_IN     DATA_IN valid (no backpressure; upstream gates on ALMOST_FULL)
//   SOP_IN       DATA_IN is the first byte of a T2-MI packet
//   PID          13-bit PID, captured when the HDR1 byte is produced
//   ALMOST_FULL  FIFO free space <= AFULL_MARGIN
//   OVF_ERR      sticky: byte or SOP position dropped
//   LEVEL        bytes currently buffered
//   TS_DATA      TS byte
//   TS_VALID     TS_DATA valid
//   TS_SOP       TS_DATA is the 0x47 sync byte
//   OUT_RDY      consumer ready; transfer when TS_VALID && OUT_RDY
// ---------------------------------------------------------------------------
module t2mi_ts_encapsulator #(
    parameter int FIFO_AW      = 9,
    parameter int SOPQ_AW      = 5,
    parameter int AFULL_MARGIN = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [7:0]         DATA_IN,
    input  logic               VALID_IN,
    input  logic               SOP_IN,
    input  logic [12:0]        PID,
    output logic               ALMOST_FULL,
    output logic               OVF_ERR,
    output logic [FIFO_AW:0]   LEVEL,
    output logic [7:0]         TS_DATA,
    output logic               TS_VALID,
    output logic               TS_SOP,
    input  logic               OUT_RDY
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int QDEPTH = 1 << SOPQ_AW;

    localparam logic [FIFO_AW:0]   LVL_FULL  = (FIFO_AW+1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LVL_AFULL = (FIFO_AW+1)'(DEPTH - AFULL_MARGIN);
    localparam logic [FIFO_AW:0]   LVL_PKT   = (FIFO_AW+1)'(184);
    localparam logic [FIFO_AW:0]   LVL_ONE   = (FIFO_AW+1)'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [SOPQ_AW-1:0] QPTR_ONE  = SOPQ_AW'(1);
    localparam logic [SOPQ_AW:0]   QCNT_ONE  = (SOPQ_AW+1)'(1);
    localparam logic [SOPQ_AW:0]   QCNT_FULL = (SOPQ_AW+1)'(QDEPTH);
    localparam logic [SOPQ_AW:0]   QCNT_ZERO = (SOPQ_AW+1)'(0);

    typedef enum logic [2:0] {
        ST_IDLE, ST_HDR0, ST_HDR1, ST_HDR2, ST_HDR3, ST_PTR, ST_AF, ST_PAY
    } state_t;

    // A: SOP inside payload (pointer), B: SOP at offset 183 (1-byte AF pad),
    // C: no SOP in this payload
    typedef enum logic [1:0] { MODE_A, MODE_B, MODE_C } mode_t;

    // byte FIFO
    logic [7:0]         fifo_mem_r [0:DEPTH-1];
    logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
    logic [FIFO_AW:0]   level_r, level_s;
    logic [15:0]        wr_abs_r, rd_abs_r;
    logic [7:0]         fifo_head_s, fifo_next_s;

    // SOP position queue
    logic [15:0]        sopq_mem_r [0:QDEPTH-1];
    logic [SOPQ_AW-1:0] sopq_wr_r, sopq_rd_r;
    logic [SOPQ_AW:0]   sopq_cnt_r;
    logic [15:0]        sopq_head_s, off_s;

    logic fifo_full_s, wr_en_s, rd_en_s, xfer_s;
    logic sopq_full_s, sopq_empty_s, sopq_push_s, sopq_pop_s;
    logic ovf_r, ovf_s, afull_r;

    // packet FSM and registered output byte
    state_t      state_r, state_s;
    mode_t       mode_r, mode_s;
    logic [3:0]  cc_r, cc_s;
    logic [12:0] pid_r, pid_s;
    logic [7:0]  ptr_r, ptr_s;
    logic [7:0]  pay_cnt_r, pay_cnt_s;
    logic [7:0]  ts_data_r, ts_data_s;
    logic        ts_valid_r, ts_valid_s;
    logic        ts_sop_r, ts_sop_s;

    assign fifo_full_s  = (level_r == LVL_FULL);
    assign wr_en_s      = VALID_IN && !fifo_full_s;
    assign xfer_s       = ts_valid_r && OUT_RDY;
    assign rd_en_s      = xfer_s && (state_r == ST_PAY);
    assign sopq_full_s  = (sopq_cnt_r == QCNT_FULL);
    assign sopq_empty_s = (sopq_cnt_r == QCNT_ZERO);
    assign sopq_push_s  = wr_en_s && SOP_IN && !sopq_full_s;
    assign sopq_head_s  = sopq_mem_r[sopq_rd_r];
    assign off_s        = sopq_head_s - rd_abs_r;
    // the head SOP leaves the queue when its own byte is sent
    assign sopq_pop_s   = rd_en_s && !sopq_empty_s && (sopq_head_s == rd_abs_r);

    // FIFO is read asynchronously so the next payload byte is ready without a bubble;
    // the byte on TS_DATA stays in the FIFO until it is actually transferred
    assign fifo_head_s  = fifo_mem_r[rd_ptr_r];
    assign fifo_next_s  = fifo_mem_r[rd_ptr_r + PTR_ONE];

    assign ALMOST_FULL = afull_r;
    assign OVF_ERR     = ovf_r;
    assign LEVEL       = level_r;
    assign TS_DATA     = ts_data_r;
    assign TS_VALID    = ts_valid_r;
    assign TS_SOP      = ts_sop_r;

    // Byte and SOP-position storage writes
    always_ff @(posedge CLK) begin
        if (wr_en_s) begin
            fifo_mem_r[wr_ptr_r] <= DATA_IN;
        end
        if (sopq_push_s) begin
            sopq_mem_r[sopq_wr_r] <= wr_abs_r;
        end
    end

    // Next FIFO level and sticky overflow flag
    always_comb begin
        level_s = level_r;
        case ({wr_en_s, rd_en_s})
            2'b10:   level_s = level_r + LVL_ONE;
            2'b01:   level_s = level_r - LVL_ONE;
            default: level_s = level_r;
        endcase
        ovf_s = ovf_r | (VALID_IN && fifo_full_s) | (VALID_IN && SOP_IN && !fifo_full_s && sopq_full_s);
    end

    // FIFO / SOP queue pointers, counters and status flags
    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            wr_abs_r   <= 16'd0;
            rd_abs_r   <= 16'd0;
            level_r    <= '0;
            sopq_wr_r  <= '0;
            sopq_rd_r  <= '0;
            sopq_cnt_r <= '0;
            ovf_r      <= 1'b0;
            afull_r    <= 1'b0;
        end else begin
            if (wr_en_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
                wr_abs_r <= wr_abs_r + 16'd1;
            end
            if (rd_en_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                rd_abs_r <= rd_abs_r + 16'd1;
            end
            if (sopq_push_s) begin
                sopq_wr_r <= sopq_wr_r + QPTR_ONE;
            end
            if (sopq_pop_s) begin
                sopq_rd_r <= sopq_rd_r + QPTR_ONE;
            end
            case ({sopq_push_s, sopq_pop_s})
                2'b10:   sopq_cnt_r <= sopq_cnt_r + QCNT_ONE;
                2'b01:   sopq_cnt_r <= sopq_cnt_r - QCNT_ONE;
                default: sopq_cnt_r <= sopq_cnt_r;
            endcase
            level_r <= level_s;
            ovf_r   <= ovf_s;
            afull_r <= (level_s >= LVL_AFULL);
        end
    end

    // FSM next state and next output byte; each step waits for a transfer
    always_comb begin
        state_s    = state_r;
        mode_s     = mode_r;
        cc_s       = cc_r;
        pid_s      = pid_r;
        ptr_s      = ptr_r;
        pay_cnt_s  = pay_cnt_r;
        ts_data_s  = ts_data_r;
        ts_valid_s = ts_valid_r;
        ts_sop_s   = ts_sop_r;
        case (state_r)
            ST_IDLE: begin
                if (level_r >= LVL_PKT) begin
                    state_s    = ST_HDR0;
                    ts_data_s  = 8'h47;
                    ts_valid_s = 1'b1;
                    ts_sop_s   = 1'b1;
                    ptr_s      = off_s[7:0];
                    if (!sopq_empty_s && (off_s <= 16'd182)) begin
                        mode_s = MODE_A;
                    end else if (!sopq_empty_s && (off_s == 16'd183)) begin
                        mode_s = MODE_B;
                    end else begin
                        mode_s = MODE_C;
                    end
                end else begin
                    ts_data_s  = 8'h00;
                    ts_valid_s = 1'b0;
                    ts_sop_s   = 1'b0;
                end
            end
            ST_HDR0: begin
                if (xfer_s) begin
                    state_s   = ST_HDR1;
                    pid_s     = PID;
                    ts_sop_s  = 1'b0;
                    ts_data_s = {1'b0, (mode_r == MODE_A), 1'b0, PID[12:8]};
                end else begin
                    state_s = ST_HDR0;
                end
            end
            ST_HDR1: begin
                if (xfer_s) begin
                    state_s   = ST_HDR2;
                    ts_data_s = pid_r[7:0];
                end else begin
                    state_s = ST_HDR1;
                end
            end
            ST_HDR2: begin
                if (xfer_s) begin
                    state_s   = ST_HDR3;
                    ts_data_s = {2'b00, ((mode_r == MODE_B) ? 2'b11 : 2'b01), cc_r};
                end else begin
                    state_s = ST_HDR2;
                end
            end
            ST_HDR3: begin
                if (xfer_s) begin
                    case (mode_r)
                        MODE_A: begin
                            state_s   = ST_PTR;
                            ts_data_s = ptr_r;
                        end
                        MODE_B: begin
                            state_s   = ST_AF;
                            ts_data_s = 8'h00;
                        end
                        default: begin
                            state_s   = ST_PAY;
                            ts_data_s = fifo_head_s;
                            pay_cnt_s = 8'd184;
                        end
                    endcase
                end else begin
                    state_s = ST_HDR3;
                end
            end
            ST_PTR, ST_AF: begin
                if (xfer_s) begin
                    state_s   = ST_PAY;
                    ts_data_s = fifo_head_s;
                    pay_cnt_s = 8'd183;
                end else begin
                    state_s = state_r;
                end
            end
            ST_PAY: begin
                if (xfer_s) begin
                    if (pay_cnt_r == 8'd1) begin
                        state_s    = ST_IDLE;
                        ts_data_s  = 8'h00;
                        ts_valid_s = 1'b0;
                        cc_s       = cc_r + 4'd1;
                    end else begin
                        ts_data_s = fifo_next_s;
                        pay_cnt_s = pay_cnt_r - 8'd1;
                    end
                end else begin
                    state_s = ST_PAY;
                end
            end
            default: begin
                state_s    = ST_IDLE;
                ts_data_s  = 8'h00;
                ts_valid_s = 1'b0;
                ts_sop_s   = 1'b0;
            end
        endcase
    end

    // FSM state and registered TS output
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r    <= ST_IDLE;
            mode_r     <= MODE_C;
            cc_r       <= 4'd0;
            pid_r      <= 13'd0;
            ptr_r      <= 8'd0;
            pay_cnt_r  <= 8'd0;
            ts_data_r  <= 8'h00;
            ts_valid_r <= 1'b0;
            ts_sop_r   <= 1'b0;
        end else begin
            state_r    <= state_s;
            mode_r     <= mode_s;
            cc_r       <= cc_s;
            pid_r      <= pid_s;
            ptr_r      <= ptr_s;
            pay_cnt_r  <= pay_cnt_s;
            ts_data_r  <= ts_data_s;
            ts_valid_r <= ts_valid_s;
            ts_sop_r   <= ts_sop_s;
        end
    end

endmodule
